// File: rtl/pwm_playback.sv
// ---------------------------------------------------------------------------
// pwm_playback
//   Reads a contiguous run of 32-bit sample words from single-port on-chip
//   memory and plays them out as PWM. Each word holds a duty compare value
//   in [CNT_W-1:0] and a repeat count in [31:16]. A repeat count of 0 plays
//   once. While the current sample plays, a one-word prefetch buffer holds
//   the next sample, so consecutive samples play back-to-back.
//
//   Optional feature macro: PWM_PLAYBACK_IRQ_EN. When defined, it adds a
//   sticky irq output, set by done or by a rising underrun, and cleared by
//   irq_ack.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start / stop      one-cycle control pulses (stop has priority)
//   loop              restart at base after the last sample (sampled at start)
//   base_addr, length first word address / sample count (sampled at start)
//   period            PWM period in clk cycles, 0 plays as 1 (sampled at start)
//   mem_address       word address; valid while mem_chipselect is high
//   mem_chipselect    high for exactly one cycle per issued read
//   mem_readdata      read data, valid the cycle after the read is issued
//   irq, irq_ack      only present with PWM_PLAYBACK_IRQ_EN
//   pwm_out           registered PWM output
//   busy              playback active
//   done              one-cycle pulse on normal completion
//   underrun          sticky; a sample boundary found the prefetch empty
// ---------------------------------------------------------------------------
module pwm_playback #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5000,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [CNT_W-1:0]  period,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  input  logic [31:0]       mem_readdata,
`ifdef PWM_PLAYBACK_IRQ_EN
  output logic              irq,
  input  logic              irq_ack,
`endif
  output logic              pwm_out,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRIME, S_RUN} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;

  // Playback configuration captured at start
  logic [ADDR_W-1:0] base_q, len_q;
  logic              loop_q;
  logic [CNT_W-1:0]  per_q;

  // Current sample, its index, and the one-word prefetch buffer
  logic [31:0]       cur_q, nbuf_q;
  logic [ADDR_W-1:0] cur_idx_q;
  logic              nvld_q;   // nbuf_q holds the next sample
  logic              pend_q;   // a prefetch read returns data this cycle

  logic [CNT_W-1:0]  cnt_q;    // position within the PWM period
  logic [15:0]       rep_q;    // periods played of the current sample

  logic pwm_q, busy_q, done_q, und_q;
  logic pwm_d, done_d;

  // -------------------------------------------------------------------------
  // Sample decode and boundary detection
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  duty;
  logic [15:0]       rpt;
  logic              per_end, rep_end, bnd;
  logic              cur_last, nidx_last, has_nxt_cur, has_nxt_n;
  logic [ADDR_W-1:0] nidx, nnidx;
  logic              sw, und_hit, fin, und_set, start_ok;

  assign duty      = cur_q[CNT_W-1:0];
  assign rpt       = (cur_q[31:16] == 16'd0) ? 16'd1 : cur_q[31:16];
  assign per_end   = (cnt_q == per_q - 1'b1);
  assign rep_end   = (rep_q == rpt - 1'b1);
  assign bnd       = (state_q == S_RUN) && per_end && rep_end;

  // Index of the sample after the current one, and the one after that; the
  // latter is what a sample switch prefetches.
  assign cur_last    = (cur_idx_q == len_q - 1'b1);
  assign nidx        = cur_last ? '0 : cur_idx_q + 1'b1;
  assign nidx_last   = (nidx == len_q - 1'b1);
  assign nnidx       = nidx_last ? '0 : nidx + 1'b1;
  assign has_nxt_cur = loop_q || !cur_last;
  assign has_nxt_n   = loop_q || !nidx_last;

  assign sw       = bnd && has_nxt_cur && nvld_q;   // switch to prefetched word
  assign und_hit  = bnd && has_nxt_cur && !nvld_q;  // replay current, flag it
  assign fin      = bnd && !has_nxt_cur;            // last sample finished
  assign und_set  = und_hit && !stop;
  assign start_ok = (state_q == S_IDLE) && start && !stop && (length != '0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_FETCH;
      S_FETCH: state_d = stop ? S_IDLE : S_PRIME;
      S_PRIME: state_d = stop ? S_IDLE : S_RUN;
      S_RUN:   if (stop || fin) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Memory reads are issued from registered state only.
  // FETCH reads index 0, PRIME prefetches index 1 (or 0 when wrapping), and
  // every switch prefetches the sample following the new current one.
  // -------------------------------------------------------------------------
  logic              cs_d;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W:0]   rd_sum, rd_wrap;

  always_comb begin
    cs_d   = 1'b0;
    rd_idx = '0;
    case (state_q)
      S_FETCH: cs_d = 1'b1;
      S_PRIME: begin
        cs_d   = has_nxt_cur;
        rd_idx = nidx;
      end
      S_RUN: if (sw && has_nxt_n) begin
        cs_d   = 1'b1;
        rd_idx = nnidx;
      end
      default: ;
    endcase
  end

  // base + index wraps modulo DEPTH; both operands are below DEPTH
  assign rd_sum  = {1'b0, base_q} + {1'b0, rd_idx};
  assign rd_wrap = (rd_sum >= DEPTH_W) ? rd_sum - DEPTH_W : rd_sum;

  assign mem_chipselect = cs_d;
  assign mem_address    = cs_d ? rd_wrap[ADDR_W-1:0] : '0;

  always_comb begin
    pwm_d  = 1'b0;
    done_d = 1'b0;
    if (state_q == S_RUN && !stop) pwm_d = (cnt_q < duty);
    if (start && !stop && state_q == S_IDLE && length == '0) done_d = 1'b1;
    if (fin && !stop) done_d = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      per_q     <= '0;
      cur_q     <= '0;
      nbuf_q    <= '0;
      cur_idx_q <= '0;
      nvld_q    <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      rep_q     <= '0;
      und_q     <= 1'b0;
    end else begin
      // Only prefetch reads land in nbuf; the FETCH read is taken by PRIME.
      pend_q <= cs_d && !stop && (state_q == S_PRIME || state_q == S_RUN);

      if (start_ok) begin
        base_q    <= base_addr;
        len_q     <= length;
        loop_q    <= loop;
        per_q     <= (period == '0) ? CNT_W'(1) : period;
        cur_idx_q <= '0;
        nvld_q    <= 1'b0;
        und_q     <= 1'b0;
      end else if (und_set) begin
        und_q <= 1'b1;
      end

      // stop drops any read still in flight
      if (stop && state_q != S_IDLE) nvld_q <= 1'b0;
      else if (pend_q) begin
        nbuf_q <= mem_readdata;
        nvld_q <= 1'b1;
      end

      if (!stop) begin
        if (state_q == S_PRIME) begin
          cur_q <= mem_readdata;
          cnt_q <= '0;
          rep_q <= '0;
        end else if (state_q == S_RUN) begin
          if (per_end) begin
            cnt_q <= '0;
            if (rep_end) begin
              rep_q <= '0;
              // on underrun, cur_q is left alone so the sample replays
              if (sw) begin
                cur_q     <= nbuf_q;
                cur_idx_q <= nidx;
                nvld_q    <= 1'b0;
              end
            end else begin
              rep_q <= rep_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      busy_q <= (state_d != S_IDLE);
      done_q <= done_d;
    end
  end

  assign pwm_out  = pwm_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = und_q;

`ifdef PWM_PLAYBACK_IRQ_EN
  logic irq_q;
  logic irq_set;

  // set wins over a coincident acknowledge
  assign irq_set = done_d | (und_set & ~und_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irq_q <= 1'b0;
    else if (irq_set) irq_q <= 1'b1;
    else if (irq_ack) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_playback.sv
module tb_pwm_playback;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop;
  logic [12:0] base_addr, length;
  logic [15:0] period;
  logic [12:0] mem_address;
  logic        mem_chipselect;
  logic [31:0] mem_readdata;
  logic        pwm_out, busy, done, underrun;
`ifdef PWM_PLAYBACK_IRQ_EN
  logic        irq, irq_ack;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  int done_cnt = 0;
  logic [31:0] bits;
  logic [12:0] alog[$];
  logic [31:0] mem [0:4999];

  pwm_playback dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .base_addr(base_addr), .length(length), .period(period),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_readdata(mem_readdata),
`ifdef PWM_PLAYBACK_IRQ_EN
    .irq(irq), .irq_ack(irq_ack),
`endif
    .pwm_out(pwm_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model: data one cycle after the select
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_readdata <= mem[mem_address];
      alog.push_back(mem_address);
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic go(input logic [12:0] b, input logic [12:0] l,
                    input logic [15:0] p, input logic lp);
    base_addr = b; length = l; period = p; loop = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // collect n pwm bits starting at the first valid output cycle
  task automatic grab(input int n);
    bits = '0;
    tick(); tick();
    for (int i = 0; i < n; i++) begin
      tick();
      bits = {bits[30:0], pwm_out};
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done && k < max) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 5000; i++) mem[i] = '0;
    mem[0]    = {16'd2, 16'd1};
    mem[1]    = {16'd1, 16'd3};
    mem[4998] = {16'd1, 16'd2};
    mem[4999] = {16'd1, 16'd2};
    mem[10]   = {16'd1, 16'd2};
    mem[20]   = {16'd1, 16'd1};
    mem[21]   = {16'd1, 16'd0};
    mem[22]   = {16'd1, 16'd1};
    mem[30]   = {16'd1, 16'd3};
    mem[40]   = {16'd2, 16'hFFFF};
    mem[41]   = {16'd2, 16'd0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    base_addr = '0; length = '0; period = '0;
`ifdef PWM_PLAYBACK_IRQ_EN
    irq_ack = 1'b0;
`endif
    #1;
    chk("rst_outs", {pwm_out, busy, done, underrun, mem_chipselect}, 32'd0);
    chk("rst_addr", {19'b0, mem_address}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset in the middle of a looping playback
    go(13'd30, 13'd1, 16'd10, 1'b1);
    repeat (6) tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {pwm_out, busy, done, underrun, mem_chipselect}, 32'd0);
    chk("mid_rst_addr", {19'b0, mem_address}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("mid_rst_idle", {busy, mem_chipselect, pwm_out}, 32'd0);

    // Two samples, non-loop: 1000 1000 1110
    alog.delete();
    go(13'd0, 13'd2, 16'd4, 1'b0);
    chk("t2_fetch", {busy, mem_chipselect}, 32'd3);
    grab(12);
    chk("t2_pwm", bits, 32'h88E);
    chk("t2_done", {31'b0, done}, 32'd1);
    chk("t2_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("t2_after", {done, pwm_out, busy}, 32'd0);
    chk("t2_nreads", alog.size(), 32'd2);
    chk("t2_under", {31'b0, underrun}, 32'd0);

    // Address wrap at DEPTH
    alog.delete();
    go(13'd4998, 13'd4, 16'd4, 1'b0);
    wait_done("t3_done", 100);
    chk("t3_nreads", alog.size(), 32'd4);
    if (alog.size() == 4) begin
      chk("t3_a0", {19'b0, alog[0]}, 32'd4998);
      chk("t3_a1", {19'b0, alog[1]}, 32'd4999);
      chk("t3_a2", {19'b0, alog[2]}, 32'd0);
      chk("t3_a3", {19'b0, alog[3]}, 32'd1);
    end
    chk("t3_under", {31'b0, underrun}, 32'd0);
    tick();

    // Single-sample loop, then stop
    done_cnt = 0;
    go(13'd10, 13'd1, 16'd5, 1'b1);
    grab(15);
    chk("t4_pwm", bits, 32'h6318);
    chk("t4_busy", {31'b0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop", {pwm_out, busy, mem_chipselect}, 32'd0);
    tick(); tick();
    chk("t4_nodone", done_cnt, 32'd0);

    // Period 1 / repeat 1: underrun replays, nothing skipped
    go(13'd20, 13'd3, 16'd1, 1'b0);
    grab(5);
    chk("t5_pwm", bits[4:0], 32'h19);
    chk("t5_done", {31'b0, done}, 32'd1);
    chk("t5_under", {31'b0, underrun}, 32'd1);
`ifdef PWM_PLAYBACK_IRQ_EN
    tick(); tick();
    chk("t5_irq_hold", {31'b0, irq}, 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t5_irq_clr", {31'b0, irq}, 32'd0);
`endif
    tick();

    // Duty at/above period and duty 0
    go(13'd40, 13'd1, 16'd8, 1'b0);
    grab(16);
    chk("t6_high", bits, 32'hFFFF);
    tick();
    go(13'd41, 13'd1, 16'd8, 1'b0);
    grab(16);
    chk("t6_low", bits, 32'h0);
    chk("t6_done", {31'b0, done}, 32'd1);
    tick();

    // start with length 0: done pulse only
    go(13'd0, 13'd0, 16'd4, 1'b0);
    chk("t7_done", {done, busy, mem_chipselect}, 32'd4);
    tick();
    chk("t7_after", {31'b0, done}, 32'd0);

    // start and stop together: stop wins
    stop = 1'b1;
    go(13'd0, 13'd2, 16'd4, 1'b0);
    stop = 1'b0;
    chk("t8_nostart", {busy, mem_chipselect}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_playback.md
# pwm_playback

Playback engine that sits directly downstream of the PWM system's 32-bit single-port on-chip sample memory. It owns that memory's read side: it fetches a contiguous run of sample words, decodes each word into a duty value and a repeat count, and drives a PWM output from them. A one-word prefetch buffer keeps consecutive samples back-to-back. The memory's write side remains with the CPU.

## Interface
- ADDR_W, 13, memory word-address width
- DEPTH, 5000, memory depth in words; address arithmetic wraps modulo DEPTH
- CNT_W, 16, width of period, duty and repeat fields
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins playback when idle
- stop  in  1  one-cycle pulse; aborts playback
- loop  in  1  sampled at start; restart at base after last sample
- base_addr  in  ADDR_W  first sample word address, sampled at start
- length  in  ADDR_W  number of samples, sampled at start
- period  in  CNT_W  PWM period in clk cycles, sampled at start
- mem_address  out  ADDR_W  memory word address
- mem_chipselect  out  1  memory select; mem write is tied 0 externally
- mem_readdata  in  32  memory data, valid the cycle after address/chipselect
- pwm_out  out  1  PWM output
- busy  out  1  playback active
- done  out  1  one-cycle pulse on normal completion
- underrun  out  1  sticky; prefetch missed a sample boundary; cleared by start
- irq  out  1  only with PWM_PLAYBACK_IRQ_EN (see Configuration)
- irq_ack  in  1  only with PWM_PLAYBACK_IRQ_EN

## Operation
- Sample word: [CNT_W-1:0] duty compare value; [31:16] repeat count (periods). Repeat 0 treated as 1.
- States: IDLE, FETCH, PRIME, RUN.
- IDLE: start=1 and length≠0: latch base_addr, length, loop, period (0 treated as 1); clear underrun; go FETCH. start with length=0 pulses done, stays IDLE.
- FETCH: drive mem_address=base, mem_chipselect=1; go PRIME.
- PRIME: capture mem_readdata into current sample; reset period counter and repeat counter to 0; go RUN.
- Prefetch: PRIME issues the read for the next index. If length=1 in loop mode, the next index is 0. The word is captured into next-buffer one cycle later and marked valid. Each sample switch issues the following read.
- Next address = base + index, minus DEPTH when the result ≥ DEPTH.
- RUN: the period counter counts 0..period-1. pwm_out = (counter < duty). duty ≥ period gives constant high; duty 0 gives constant low.
- Sample boundary (counter=period-1 and repeat counter=repeat-1) when more samples remain or loop=1:
  - next-buffer valid: load it as current and clear valid.
  - next-buffer not valid: repeat current sample one more period and set underrun.
- Last sample boundary with loop=0: go IDLE, pulse done, pwm_out low.
- stop in any non-IDLE state: go IDLE next cycle. pwm_out, busy and mem_chipselect go 0. No done pulse. Any in-flight read is discarded.
- start while busy is ignored. start and stop in the same cycle: stop wins.

## Timing
- Reset values: pwm_out 0, busy 0, done 0, underrun 0, irq 0, mem_chipselect 0, mem_address 0; state IDLE.
- start at edge T: FETCH in cycle T+1, data captured at T+2, first pwm_out cycle valid at T+3 (registered output).
- busy is high from T+1 through the final cycle before IDLE.
- mem_chipselect is asserted only in read-issue cycles (one cycle per read).
- Prefetch needs 2 cycles; no underrun when period × repeat ≥ 3.
- pwm_out, busy and done are registered, with no combinational path from inputs.

## Configuration
- PWM_PLAYBACK_IRQ_EN defined:
  - irq is a sticky level, set when done pulses or underrun rises.
  - irq clears on irq_ack; set wins if set and irq_ack coincide.
  - Ports irq and irq_ack exist.
- PWM_PLAYBACK_IRQ_EN undefined: ports irq and irq_ack and their logic are absent.

## Test plan
- Reset mid-RUN (period 10, duty 3) -> all outputs 0 immediately; state IDLE after release.
- base 0, length 2, period 4, words {repeat 2, duty 1}, {repeat 1, duty 3} -> pwm_out sequence 1000 1000 1110, then done pulse, busy low.
- base 4998, length 4 -> reads addresses 4998, 4999, 0, 1, in order.
- loop=1, length 1, duty 2, period 5 -> continuous 11000 pattern, no done; stop -> pwm_out 0 next cycle, no done.
- period 1, repeat 1, length 3 -> underrun set, no sample skipped; with IRQ_EN, irq high until irq_ack.
- duty 0xFFFF with period 8 -> pwm_out constant high; duty 0 -> constant low.
